// File: rtl/prio_rr_arbiter.sv
// ---------------------------------------------------------------------------
// prio_rr_arbiter
//   Arbitrates NUM_CLIENTS requesters onto one downstream server. Each client
//   carries a PRIO_W-bit priority (0 = most urgent). Both sides use a full
//   four-phase rq/ack handshake and the winner stays locked from grant until
//   its handshake has fully returned to zero. Ties at the best priority go to
//   the lowest index (TIE_MODE=0) or rotate round-robin after the last
//   granted index (TIE_MODE=1).
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high
//   client_priority priority of client i in [i*PRIO_W +: PRIO_W]
//   client_rq       per-client request, held until that client's ack
//   client_ack      per-client acknowledge, registered, one-hot or zero
//   server_rq       request to the server, registered
//   server_ack      acknowledge from the server
//   grant_valid     high while a winner is locked
//   grant_id        index of the locked winner, holds its value when idle
// ---------------------------------------------------------------------------

// Per-client slice: builds a sortable key (non-requesters sort last) and
// flags whether this client sits at the best priority among requesters.
module prio_rr_arbiter_lane #(
    parameter int PRIO_W = 2
) (
    input  logic              rq,
    input  logic [PRIO_W-1:0] prio,
    input  logic [PRIO_W:0]   best_key,
    output logic [PRIO_W:0]   key,
    output logic              tied
);

    // MSB set for idle clients so any requester beats them in a min search.
    assign key  = {~rq, prio};
    assign tied = rq & (key == best_key);

endmodule

module prio_rr_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int PRIO_W      = 2,
    parameter int TIE_MODE    = 0,
    parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS*PRIO_W-1:0] client_priority,
    input  logic [NUM_CLIENTS-1:0]        client_rq,
    output logic [NUM_CLIENTS-1:0]        client_ack,
    output logic                          server_rq,
    input  logic                          server_ack,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SACK = 2'd1,
        HOLD      = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic                    server_rq_n;
    logic [NUM_CLIENTS-1:0]  client_ack_n;
    logic                    grant_valid_n;
    logic [ID_W-1:0]         grant_id_n;
    logic [ID_W-1:0]         rr_last, rr_last_n;

    logic [NUM_CLIENTS-1:0][PRIO_W:0] key;
    logic [PRIO_W:0]                  best_key;
    logic [NUM_CLIENTS-1:0]           tied;
    logic [ID_W-1:0]                  win_id;

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
        prio_rr_arbiter_lane #(
            .PRIO_W   (PRIO_W)
        ) u_lane (
            .rq       (client_rq[i]),
            .prio     (client_priority[i*PRIO_W +: PRIO_W]),
            .best_key (best_key),
            .key      (key[i]),
            .tied     (tied[i])
        );
    end

    always_comb begin
        best_key = key[0];
        for (int i = 1; i < NUM_CLIENTS; i++) begin
            if (key[i] < best_key) best_key = key[i];
        end
    end

    // Tie-break among the clients flagged in 'tied'.
    logic [ID_W:0]   rr_sum;
    logic [ID_W-1:0] rr_idx;
    logic            found;

    always_comb begin
        win_id = '0;
        rr_sum = '0;
        rr_idx = '0;
        found  = 1'b0;
        if (TIE_MODE == 0) begin
            // Descending scan so the lowest tied index is written last.
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (tied[i]) win_id = ID_W'(i);
            end
        end else begin
            // Scan rr_last+1, rr_last+2, ... with wrap; first tied wins.
            for (int k = 0; k < NUM_CLIENTS; k++) begin
                rr_sum = {1'b0, rr_last} + (ID_W+1)'(k + 1);
                if (rr_sum >= (ID_W+1)'(NUM_CLIENTS))
                    rr_sum = rr_sum - (ID_W+1)'(NUM_CLIENTS);
                rr_idx = rr_sum[ID_W-1:0];
                if (!found && tied[rr_idx]) begin
                    win_id = rr_idx;
                    found  = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Handshake FSM: next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        server_rq_n   = server_rq;
        client_ack_n  = client_ack;
        grant_valid_n = grant_valid;
        grant_id_n    = grant_id;
        rr_last_n     = rr_last;
        case (state)
            IDLE: begin
                // server_ack is ignored here; only a client request starts a grant.
                if (|client_rq) begin
                    grant_id_n    = win_id;
                    grant_valid_n = 1'b1;
                    server_rq_n   = 1'b1;
                    state_n       = WAIT_SACK;
                end
            end
            WAIT_SACK: begin
                // Server ack takes precedence over a simultaneous client abort.
                if (server_ack) begin
                    client_ack_n           = '0;
                    client_ack_n[grant_id] = 1'b1;
                    state_n                = HOLD;
                end else if (!client_rq[grant_id]) begin
                    server_rq_n = 1'b0;
                    state_n     = RELEASE;
                end
            end
            HOLD: begin
                if (!client_rq[grant_id]) begin
                    server_rq_n  = 1'b0;
                    client_ack_n = '0;
                    state_n      = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the server to finish its half of the handshake.
                if (!server_ack) begin
                    grant_valid_n = 1'b0;
                    state_n       = IDLE;
                    if (TIE_MODE != 0) rr_last_n = grant_id;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            server_rq   <= 1'b0;
            client_ack  <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            // Pointing at the last client makes client 0 win the first tie.
            rr_last     <= ID_W'(NUM_CLIENTS - 1);
        end else begin
            state       <= state_n;
            server_rq   <= server_rq_n;
            client_ack  <= client_ack_n;
            grant_valid <= grant_valid_n;
            grant_id    <= grant_id_n;
            rr_last     <= rr_last_n;
        end
    end

endmodule
